fir_sequencer: RTL and testbench
================================

// Module: fir_sequencer
// PURPOSE
//  Sequences the Fir datapath. Loads NUM_TAPS coefficients (control=0), then streams
//  samples (control=1), with valid/ready handshakes on both inputs. Drives Fir's
//  enable/control/b/x pins, captures Fir data_out and returns results with out_valid.
//  Sits between the coefficient/sample sources and the Fir instance.
// PARAMETERS
//  DATA_WIDTH   32  width of coefficients, samples and results
//  NUM_TAPS     8   coefficients per load; tap counter is $clog2(NUM_TAPS+1) bits
//  FIR_LATENCY  1   cycles from a Fir enable edge until data_out is valid (>=1)
// PORTS
//  clk          in   1    clock, rising edge
//  reset_n      in   1    asynchronous reset, active low
//  cfg_start    in   1    pulse: begin or restart a coefficient load
//  coef_data    in   DW   coefficient value
//  coef_valid   in   1    coef_data is valid
//  coef_ready   out  1    coefficient accepted when coef_valid && coef_ready
//  samp_data    in   DW   input sample
//  samp_valid   in   1    samp_data is valid
//  samp_ready   out  1    sample accepted when samp_valid && samp_ready
//  fir_enable   out  1    to Fir enable; one-cycle pulse per transfer
//  fir_control  out  1    to Fir control: 0 = coefficient load, 1 = sample run
//  fir_b        out  DW   to Fir b
//  fir_x        out  DW   to Fir x
//  fir_data     in   DW   from Fir data_out
//  out_data     out  DW   captured result
//  out_valid    out  1    one-cycle strobe. There is no backpressure; the sink must take every result.
//  loaded       out  1    full coefficient set present
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE and tap_cnt=0. All outputs are 0, the valid pipe is cleared, and loaded=0.
//  Registered outputs: fir_enable, fir_control, fir_b, fir_x, out_data, out_valid, loaded.
//  coef_ready and samp_ready are combinational from state.
//  FSM:
//   IDLE : no ready. cfg_start -> LOAD, tap_cnt=0, loaded=0.
//   LOAD : coef_ready=1. Each accept: fir_b<=coef_data, fir_control<=0, fir_enable<=1 for 1 cycle,
//          tap_cnt++. The accept with tap_cnt==NUM_TAPS-1 -> RUN, loaded<=1. cfg_start is ignored.
//   RUN  : samp_ready = !cfg_start. Each accept: fir_x<=samp_data, fir_control<=1,
//          fir_enable<=1 for 1 cycle, and a 1 is pushed into a FIR_LATENCY+1 deep valid pipe.
//          cfg_start -> DRAIN. cfg_start beats a simultaneous samp_valid; that sample is not accepted.
//   DRAIN: no ready, fir_enable=0. When the valid pipe is empty -> LOAD, tap_cnt=0, loaded=0.
//  Latency: a sample accepted at edge k produces out_valid=1 and out_data=fir_data (sampled at
//   edge k+FIR_LATENCY+1), for exactly the cycle after that edge. Full throughput is 1 sample/cycle.
//  fir_b and fir_x hold their last value when fir_enable=0. fir_control holds its value outside transfers.
//  Inputs presented outside the owning state (coef in IDLE/RUN/DRAIN, samp in IDLE/LOAD/DRAIN)
//   are ignored and produce no fir_enable pulse.
//  Reset asserted mid-operation aborts everything. In-flight results are discarded and
//   coefficients must be reloaded in full.
// TESTING
//  1 cfg_start, then coef 1..8 with valid held high -> 8 fir_enable pulses with fir_control=0 and
//    fir_b=1..8. coef_ready drops after the 8th accept and loaded=1.
//  2 In RUN, samples 1..8 with 1-cycle gaps -> fir_x=1..8 and exactly 8 out_valid strobes, each
//    FIR_LATENCY+1 cycles after its accept.
//  3 cfg_start in the same cycle as samp_valid (sample 9) -> not accepted, samp_ready=0. Earlier
//    in-flight results still produce out_valid. State goes to LOAD once the pipe is empty, then loaded=0.
//  4 reset_n low after 3 of 8 coefs -> all outputs 0 immediately. A new load needs all 8 coefs.
//  5 coef_valid and samp_valid high in IDLE for 10 cycles -> no fir_enable, no ready, busy=0.
//  6 NUM_TAPS=1, FIR_LATENCY=3 -> LOAD->RUN after one accept, and out_valid appears 4 cycles after
//    each sample accept.

Source files
------------

// File: rtl/fir_sequencer.sv
// -----------------------------------------------------------------------------
// fir_sequencer
//   Control sequencer for a Fir datapath. It loads NUM_TAPS coefficients into
//   the Fir (control=0) and then streams samples through it (control=1). The
//   results are captured FIR_LATENCY+1 cycles after each sample is accepted.
//   A cfg_start pulse during streaming drains in-flight results, then begins a
//   fresh coefficient load.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   cfg_start               pulse: begin or restart a coefficient load
//   coef_data/valid/ready   coefficient stream (accepted only in LOAD)
//   samp_data/valid/ready   sample stream (accepted only in RUN)
//   fir_enable/control/b/x  registered drive of the Fir pins
//   fir_data                Fir data_out
//   out_data/out_valid      captured result with a one-cycle strobe, no backpressure
//   loaded                  a full coefficient set is present
//   busy                    sequencer is not idle
// -----------------------------------------------------------------------------
module fir_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_TAPS    = 8,
  parameter int FIR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_start,
  input  logic [DATA_WIDTH-1:0] coef_data,
  input  logic                  coef_valid,
  output logic                  coef_ready,
  input  logic [DATA_WIDTH-1:0] samp_data,
  input  logic                  samp_valid,
  output logic                  samp_ready,
  output logic                  fir_enable,
  output logic                  fir_control,
  output logic [DATA_WIDTH-1:0] fir_b,
  output logic [DATA_WIDTH-1:0] fir_x,
  input  logic [DATA_WIDTH-1:0] fir_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  loaded,
  output logic                  busy
);

  localparam int TapW = $clog2(NUM_TAPS + 1);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Load  = 2'd1,
    Run   = 2'd2,
    Drain = 2'd3
  } stateT;

  stateT                stateQ;
  stateT                stateD;
  logic [TapW-1:0]      tapCnt;
  // Bit i set means a sample accepted i edges ago is still on its way out of the Fir.
  logic [FIR_LATENCY:0] validPipe;

  logic coefAccept;
  logic sampAccept;
  logic lastTap;
  logic pipeEmpty;
  logic enterLoad;

  assign coefAccept = coef_valid && coef_ready;
  assign sampAccept = samp_valid && samp_ready;
  assign lastTap    = (tapCnt == TapW'(NUM_TAPS - 1));
  assign pipeEmpty  = (validPipe == '0);
  assign enterLoad  = (stateD == Load) && (stateQ != Load);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stateQ <= Idle;
    else          stateQ <= stateD;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred for stateD.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      Idle:    if (cfg_start)               stateD = Load;
      Load:    if (coefAccept && lastTap)   stateD = Run;
      Run:     if (cfg_start)               stateD = Drain;
      Drain:   if (pipeEmpty)               stateD = Load;
      default:                              stateD = Idle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  // cfg_start wins over a simultaneous sample: ready is withheld so that
  // sample stays with its source.
  always_comb begin
    coef_ready = (stateQ == Load);
    samp_ready = (stateQ == Run) && !cfg_start;
    busy       = (stateQ != Idle);
  end

  // ---------------------------------------------------------------------------
  // Tap counter and coefficient-set status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tapCnt <= '0;
      loaded <= 1'b0;
    end else if (enterLoad) begin
      tapCnt <= '0;
      loaded <= 1'b0;
    end else if (coefAccept) begin
      tapCnt <= tapCnt + TapW'(1);
      if (lastTap) loaded <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Fir pin drive: one enable pulse per transfer, operands hold between them
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fir_enable  <= 1'b0;
      fir_control <= 1'b0;
      fir_b       <= '0;
      fir_x       <= '0;
    end else begin
      fir_enable <= coefAccept || sampAccept;
      if (coefAccept) begin
        fir_b       <= coef_data;
        fir_control <= 1'b0;
      end
      if (sampAccept) begin
        fir_x       <= samp_data;
        fir_control <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result tracking: the valid pipe mirrors the Fir latency plus the register
  // stage on fir_enable, so the tail bit marks the edge at which fir_data holds
  // the result for that sample.
  // ---------------------------------------------------------------------------
  // NOTE: the valid pipe is reset (unlike a data-only store) because stale
  // bits would raise spurious out_valid strobes after a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      validPipe <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      validPipe <= {validPipe[FIR_LATENCY-1:0], sampAccept};
      out_valid <= validPipe[FIR_LATENCY];
      if (validPipe[FIR_LATENCY]) out_data <= fir_data;
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_sequencer
//   Directed bench for fir_sequencer. u0 uses the default configuration
//   (8 taps, latency 1); u1 uses a single tap with latency 3. fir_data is driven
//   with the free-running cycle count, so every captured result identifies the
//   exact edge at which it was sampled.
// -----------------------------------------------------------------------------
module tb_fir_sequencer;

  localparam int DW = 32;
  localparam int L0 = 1;
  localparam int L1 = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] firData;
  assign firData = DW'(cyc);

  // u0 signals
  logic          cfgStart = 1'b0;
  logic [DW-1:0] coefData = '0;
  logic          coefValid = 1'b0;
  logic          coefReady;
  logic [DW-1:0] sampData = '0;
  logic          sampValid = 1'b0;
  logic          sampReady;
  logic          firEnable, firControl, outValid, loaded, busy;
  logic [DW-1:0] firB, firX, outData;

  // u1 signals
  logic          cfgStart1 = 1'b0;
  logic [DW-1:0] coefData1 = '0;
  logic          coefValid1 = 1'b0;
  logic          coefReady1;
  logic [DW-1:0] sampData1 = '0;
  logic          sampValid1 = 1'b0;
  logic          sampReady1;
  logic          firEnable1, firControl1, outValid1, loaded1, busy1;
  logic [DW-1:0] firB1, firX1, outData1;

  fir_sequencer #(.DATA_WIDTH(DW), .NUM_TAPS(8), .FIR_LATENCY(L0)) u0 (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfgStart),
    .coef_data(coefData), .coef_valid(coefValid), .coef_ready(coefReady),
    .samp_data(sampData), .samp_valid(sampValid), .samp_ready(sampReady),
    .fir_enable(firEnable), .fir_control(firControl), .fir_b(firB), .fir_x(firX),
    .fir_data(firData), .out_data(outData), .out_valid(outValid),
    .loaded(loaded), .busy(busy)
  );

  fir_sequencer #(.DATA_WIDTH(DW), .NUM_TAPS(1), .FIR_LATENCY(L1)) u1 (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfgStart1),
    .coef_data(coefData1), .coef_valid(coefValid1), .coef_ready(coefReady1),
    .samp_data(sampData1), .samp_valid(sampValid1), .samp_ready(sampReady1),
    .fir_enable(firEnable1), .fir_control(firControl1), .fir_b(firB1), .fir_x(firX1),
    .fir_data(firData), .out_data(outData1), .out_valid(outValid1),
    .loaded(loaded1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for u0 results: the negedge cycle count at which out_valid is
  // expected, and the fir_data value that must have been captured.
  typedef struct {
    int cycAt;
    int data;
  } expT;
  expT expQ[$];

  always @(negedge clk) begin
    if (outValid) begin
      strobes++;
      if (expQ.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        expT e;
        e = expQ.pop_front();
        check("out_valid_timing", 64'(cyc), 64'(e.cycAt));
        check("out_data", 64'(outData), 64'(e.data));
      end
    end
  end

  task automatic pushExpected();
    expT e;
    // Called #1 after the accepting edge; cyc has already advanced past it.
    e.cycAt = cyc + L0 + 1;
    e.data  = cyc + L0;
    expQ.push_back(e);
  endtask

  initial begin
    int acc;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_fir_enable", 64'(firEnable), 0);
    check("rst_fir_control", 64'(firControl), 0);
    check("rst_fir_b", 64'(firB), 0);
    check("rst_fir_x", 64'(firX), 0);
    check("rst_out_data", 64'(outData), 0);
    check("rst_out_valid", 64'(outValid), 0);
    check("rst_loaded", 64'(loaded), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_coef_ready", 64'(coefReady), 0);
    check("rst_samp_ready", 64'(sampReady), 0);
    reset_n = 1'b1;
    tick();

    // ---------------- inputs ignored in IDLE ----------------
    coefValid = 1'b1; coefData = 32'hDEAD;
    sampValid = 1'b1; sampData = 32'hBEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_fir_enable", 64'(firEnable), 0);
      check("idle_coef_ready", 64'(coefReady), 0);
      check("idle_samp_ready", 64'(sampReady), 0);
      check("idle_busy", 64'(busy), 0);
    end
    coefValid = 1'b0; sampValid = 1'b0;
    check("idle_fir_b", 64'(firB), 0);

    // ---------------- coefficient load 1..8 ----------------
    cfgStart = 1'b1;
    tick();
    cfgStart = 1'b0;
    #1;
    check("load_busy", 64'(busy), 1);
    check("load_loaded", 64'(loaded), 0);
    coefValid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      coefData = DW'(i);
      #1;
      check("load_coef_ready", 64'(coefReady), 1);
      tick();
      check("load_fir_enable", 64'(firEnable), 1);
      check("load_fir_control", 64'(firControl), 0);
      check("load_fir_b", 64'(firB), 64'(i));
      check("load_loaded_now", 64'(loaded), (i == 8) ? 64'd1 : 64'd0);
    end
    coefValid = 1'b0;
    #1;
    check("load_done_coef_ready", 64'(coefReady), 0);
    check("run_samp_ready", 64'(sampReady), 1);
    tick();
    check("load_done_no_enable", 64'(firEnable), 0);
    check("load_hold_fir_b", 64'(firB), 8);

    // ---------------- samples 1..8 with 1-cycle gaps ----------------
    for (int i = 1; i <= 8; i++) begin
      sampValid = 1'b1; sampData = DW'(i);
      #1;
      check("run_samp_ready", 64'(sampReady), 1);
      tick();
      pushExpected();
      sampValid = 1'b0;
      check("run_fir_enable", 64'(firEnable), 1);
      check("run_fir_control", 64'(firControl), 1);
      check("run_fir_x", 64'(firX), 64'(i));
      if (i < 8) begin
        tick();
        check("gap_fir_enable", 64'(firEnable), 0);
        check("gap_fir_x_hold", 64'(firX), 64'(i));
      end
    end

    // ---------------- cfg_start beats sample 9, drain ----------------
    cfgStart = 1'b1; sampValid = 1'b1; sampData = 32'd9;
    #1;
    check("restart_samp_ready", 64'(sampReady), 0);
    tick();
    cfgStart = 1'b0; sampValid = 1'b0;
    check("restart_no_enable", 64'(firEnable), 0);
    check("restart_fir_x", 64'(firX), 8);
    check("drain_coef_ready", 64'(coefReady), 0);
    check("drain_busy", 64'(busy), 1);
    for (int i = 0; i < 20 && !coefReady; i++) tick();
    check("drain_to_load", 64'(coefReady), 1);
    check("reload_loaded", 64'(loaded), 0);
    check("strobe_count", 64'(strobes), 8);
    check("scoreboard_empty", 64'(expQ.size()), 0);

    // ---------------- reset after 3 of 8 coefficients ----------------
    coefValid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      coefData = DW'(100 + i);
      tick();
    end
    coefValid = 1'b0;
    check("part_fir_b", 64'(firB), 103);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_fir_enable", 64'(firEnable), 0);
    check("abort_fir_control", 64'(firControl), 0);
    check("abort_fir_b", 64'(firB), 0);
    check("abort_fir_x", 64'(firX), 0);
    check("abort_out_data", 64'(outData), 0);
    check("abort_busy", 64'(busy), 0);
    check("abort_loaded", 64'(loaded), 0);
    tick();
    reset_n = 1'b1;
    tick();
    cfgStart = 1'b1;
    tick();
    cfgStart = 1'b0;
    coefValid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      coefData = DW'(200 + i);
      tick();
      check("reload_loaded_step", 64'(loaded), (i == 8) ? 64'd1 : 64'd0);
    end
    coefValid = 1'b0;
    check("reload_fir_b", 64'(firB), 208);

    // ---------------- u1: one tap, latency 3 ----------------
    cfgStart1 = 1'b1;
    tick();
    cfgStart1 = 1'b0;
    coefValid1 = 1'b1; coefData1 = 32'd5;
    #1;
    check("u1_coef_ready", 64'(coefReady1), 1);
    tick();
    coefValid1 = 1'b0;
    #1;
    check("u1_fir_b", 64'(firB1), 5);
    check("u1_loaded", 64'(loaded1), 1);
    check("u1_in_run", 64'(sampReady1), 1);
    check("u1_coef_ready_off", 64'(coefReady1), 0);
    sampValid1 = 1'b1; sampData1 = 32'd7;
    tick();
    acc = cyc;
    sampValid1 = 1'b0;
    check("u1_fir_x", 64'(firX1), 7);
    check("u1_fir_control", 64'(firControl1), 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("u1_out_valid_early", 64'(outValid1), 0);
    end
    tick();
    check("u1_out_valid", 64'(outValid1), 1);
    check("u1_out_data", 64'(outData1), 64'(acc + L1));
    tick();
    check("u1_out_valid_pulse", 64'(outValid1), 0);
    check("u0_no_stray_strobes", 64'(strobes), 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
